memory_access: RTL
==================

Name: memory_access

Overview:
- Memory-access (MA) pipeline stage. Consumes the EX/MA register outputs (alu_ma, rs2_ma, rd0_*_ma, data_*_en_ma, funct3_ma).
- Drives a request/acknowledge data-memory port with byte-lane alignment for stores and sign/zero extension for loads.
- Registers the MA/WB payload, which is rd0_data back to EX forwarding and to the register file.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
XLEN, 32, data/address width (must equal dataBus_u width)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
clk_en  in  1  pipeline clock enable from hazard control
flush  in  1  discard current MA instruction (insert NOP into WB)
alu_ma  in  XLEN  ALU result / effective address
rs2_ma  in  XLEN  store data
rd0_wr_en_ma  in  1  rd write enable
data_rd_en_ma  in  1  load
data_wr_en_ma  in  1  store
funct3_ma  in  3 (funct3ITypeLOAD_e)  access size/sign
rd0_addr_ma  in  5 (regAddr_t)  rd address
dmem_req  out  1  memory request
dmem_we  out  1  write when 1
dmem_addr  out  XLEN  word-aligned address
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_ack  in  1  request accepted/completed (may be same cycle as req)
dmem_rdata  in  XLEN  read word, valid with ack
ma_stall  out  1  hold upstream stages
rd0_data  out  XLEN  WB data (also EX forward)
rd0_wr_en_wb  out  1  WB write enable
rd0_addr_wb  out  5  WB rd address

Behaviour:
- access = data_rd_en_ma | data_wr_en_ma; data_wr_en_ma has priority if both set (dmem_we=1).
- FSM maState_e: IDLE, WAIT, DRAIN.
  - IDLE: dmem_req = access. If ack is set the same cycle, stay in IDLE. Else, if access, go to WAIT.
  - WAIT: dmem_req=1 with inputs held. On ack, go to IDLE. If flush && !ack, go to DRAIN.
  - DRAIN: dmem_req=1. Result is discarded. On ack, go to IDLE.
- ma_stall = (IDLE & access & !ack) | WAIT & !ack | DRAIN. Combinational.
- dmem_addr = {alu_ma[XLEN-1:2],2'b00}.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- Loads: dmem_be follows the same size rules. Extraction uses addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- WB register updates when clk_en && !ma_stall:
  - rd0_data = load ? aligned dmem_rdata (captured on ack) : alu_ma.
  - rd0_wr_en_wb and rd0_addr_wb are copied from the _ma inputs.
- Latency: load data appears on rd0_data one clk after the ack cycle.
- flush (sync) takes priority over the WB update: rd0_data=0, rd0_wr_en_wb=0, rd0_addr_wb=0. flush never aborts a bus transaction; a store already requested completes.
- rst: all outputs 0, state IDLE. dmem_req is forced 0 while rst=1, even mid-WAIT. The memory must tolerate an abandoned request.
- Non-access instruction: no req, no stall, WB updates each enabled cycle.
- Back-to-back accesses: a new request may assert in the cycle after an ack.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no dmem_req and no stall.
  - rd0_wr_en_wb is forced 0.
  - An added output misalign_exc (1 bit, reset 0) pulses for one cycle, registered with the WB update.
- Undefined: misaligned accesses proceed silently. Halfword uses addr[1] only; word ignores addr[1:0]. No misalign_exc port exists.

Decomposition:
- riscv_definitions package:
  - maState_e {IDLE, WAIT, DRAIN}
  - dmemBe_t (logic [3:0])
  - constant BE_ALL = 4'b1111
  - funct3ITypeLOAD_e reused for store sizes (SB=LB, SH=LH, SW=LW)
- One sub-module, lsu_align: combinational; generates be/wdata from (funct3, addr[1:0], rs2) and extracts/extends load data from (funct3, addr[1:0], rdata).

Test Plan:
- SB, alu_ma=0x1003, rs2=0xAABBCCDD, ack same cycle:
  - Response: dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, ma_stall=0.
- LB, alu_ma=0x2002, rdata=0x00F00000, ack after 3 cycles:
  - ma_stall high exactly 3 cycles.
  - Next cycle: rd0_data=0xFFFFFFF0, rd0_wr_en_wb=1.
- LHU, addr 0x2002, rdata=0x8001_1234 -> rd0_data=0x00008001. LH, same inputs -> rd0_data=0xFFFF8001.
- ADD result 0x55, no access -> no dmem_req; rd0_data=0x55 one cycle later.
- flush during WAIT, ack 2 cycles later:
  - dmem_req is held until ack and ma_stall stays high through DRAIN.
  - rd0_wr_en_wb=0.
- rst asserted mid-WAIT -> dmem_req=0 that cycle, all outputs 0 next cycle. With MISALIGN_TRAP_EN, LW at 0x3001 -> no req, misalign_exc=1 for one cycle.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// Shared types for the memory-access stage: FSM states, load/store size codes,
// byte-enable and data-bus types, and the held data-memory request payload.
package riscv_definitions_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [4:0] regAddr_t;
    typedef logic [3:0] dmemBe_t;

    localparam dmemBe_t BE_ALL = 4'b1111;

    // Store sizes reuse the load encodings: SB=LB, SH=LH, SW=LW.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3ITypeLOAD_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } maState_e;

    typedef union packed {
        logic [DATA_W-1:0]    w;
        logic [3:0][7:0]      b;
        logic [1:0][15:0]     h;
    } dataBus_u;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        dmemBe_t           be;
        logic [DATA_W-1:0] wdata;
    } dmemReq_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/replicated write data and load extraction
// with sign or zero extension, selected by access size and address low bits.
module lsu_align
    import riscv_definitions_pkg::*;
(
    input  funct3ITypeLOAD_e    funct3,
    input  logic [1:0]          addr_lo,
    input  logic [DATA_W-1:0]   rs2,
    input  logic [DATA_W-1:0]   rdata,
    output dmemBe_t             be,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   ld_data
);

    dataBus_u    rd_u;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sign_b;
    logic        sign_h;

    assign rd_u    = rdata;
    assign ld_byte = rd_u.b[addr_lo];
    assign ld_half = rd_u.h[addr_lo[1]];
    assign sign_b  = (funct3 == LB) & ld_byte[7];
    assign sign_h  = (funct3 == LH) & ld_half[15];

    always_comb begin
        be      = BE_ALL;
        wdata   = rs2;
        ld_data = rdata;
        case (funct3)
            LB, LBU: begin
                be      = dmemBe_t'(4'b0001 << addr_lo);
                wdata   = {4{rs2[7:0]}};
                ld_data = {{(DATA_W-8){sign_b}}, ld_byte};
            end
            LH, LHU: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{rs2[15:0]}};
                ld_data = {{(DATA_W-16){sign_h}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MA pipeline stage: req/ack data-memory port, stall generation and MA/WB register.
// Optional MISALIGN_TRAP_EN suppresses misaligned accesses and raises misalign_exc.
module memory_access
    import riscv_definitions_pkg::*;
#(
    parameter int unsigned XLEN = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              flush,
    input  logic [XLEN-1:0]   alu_ma,
    input  logic [XLEN-1:0]   rs2_ma,
    input  logic              rd0_wr_en_ma,
    input  logic              data_rd_en_ma,
    input  logic              data_wr_en_ma,
    input  funct3ITypeLOAD_e  funct3_ma,
    input  regAddr_t          rd0_addr_ma,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output dmemBe_t           dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              ma_stall,
    output logic [XLEN-1:0]   rd0_data,
    output logic              rd0_wr_en_wb,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_exc,
`endif
    output regAddr_t          rd0_addr_wb
);

    maState_e          state;
    dmemReq_t          live_req;
    dmemReq_t          held_req;
    dmemReq_t          bus;
    dmemBe_t           lane_be;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   ld_data;
    logic              misaligned;
    logic              access;
    logic              is_load;

    lsu_align u_align (
        .funct3  (funct3_ma),
        .addr_lo (alu_ma[1:0]),
        .rs2     (rs2_ma),
        .rdata   (dmem_rdata),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .ld_data (ld_data)
    );

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (data_rd_en_ma | data_wr_en_ma) &
                        (((funct3_ma[1:0] == 2'b01) & alu_ma[0]) |
                         ((funct3_ma[1:0] == 2'b10) & (|alu_ma[1:0])));
`else
    assign misaligned = 1'b0;
`endif

    assign access   = (data_rd_en_ma | data_wr_en_ma) & ~misaligned;
    assign is_load  = data_rd_en_ma & ~data_wr_en_ma & ~misaligned;
    assign live_req = {data_wr_en_ma, {alu_ma[XLEN-1:2], 2'b00}, lane_be, lane_wdata};
    // Once a request is pending the bus replays the captured payload, so a flush
    // that clears the EX/MA register cannot corrupt the outstanding transaction.
    assign bus      = (state == IDLE) ? live_req : held_req;

    // Bus handshake and stall; everything forced low during reset.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        ma_stall   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    dmem_req = access;
                    ma_stall = access & ~dmem_ack;
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    ma_stall = ~dmem_ack;
                end
                DRAIN: begin
                    dmem_req = 1'b1;
                    ma_stall = 1'b1;
                end
                default: ;
            endcase
            if (dmem_req) begin
                dmem_we    = bus.we;
                dmem_addr  = bus.addr;
                dmem_be    = bus.be;
                dmem_wdata = bus.wdata;
            end
        end
    end

    // Request FSM and MA/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            held_req     <= '0;
            rd0_data     <= '0;
            rd0_wr_en_wb <= 1'b0;
            rd0_addr_wb  <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (access && !dmem_ack) begin
                    held_req <= live_req;
                    // A flush on the issue cycle already discards the result.
                    state    <= flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (dmem_ack)  state <= IDLE;
                    else if (flush) state <= DRAIN;
                end
                DRAIN: if (dmem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
            if (flush) begin
                rd0_data     <= '0;
                rd0_wr_en_wb <= 1'b0;
                rd0_addr_wb  <= '0;
            end else if (clk_en && !ma_stall) begin
                rd0_data     <= is_load ? ld_data : alu_ma;
                rd0_wr_en_wb <= rd0_wr_en_ma & ~misaligned;
                rd0_addr_wb  <= rd0_addr_ma;
`ifdef MISALIGN_TRAP_EN
                misalign_exc <= misaligned;
`endif
            end
        end
    end

endmodule
